// File: rtl/axi_to_apb_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to APB3 bridge.
// Contents:
//   cmd_t        - request crossing AXI -> APB: {write, addr, data}
//   rsp_t        - response crossing APB -> AXI: {write, rdata, slverr}
//   RESP_*       - AXI response encodings used by the bridge
//   apb_state_e  - states of the APB master FSM
//   slverrToResp - maps an APB slave error flag onto an AXI response code
// The struct layouts match the default 32-bit bridge. The bridge itself
// packs its FIFO words by hand so that it stays parameterisable.
package axi_to_apb_bridge_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    typedef struct packed {
        logic              write;
        logic [DATA_W-1:0] rdata;
        logic              slverr;
    } rsp_t;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;

    function automatic logic [1:0] slverrToResp(input logic slverr);
        return slverr ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_to_apb_bridge_fifo.sv
// Dual-clock FIFO that uses binary and gray pointers.
// Ports:
//   wclk_i, wrstn_i            - write clock and write-side async active-low reset
//   winc_i, wdata_i, wfull_o   - push request, push data, full flag
//   rclk_i, rrstn_i            - read clock and read-side async active-low reset
//   rinc_i, rdata_o, rempty_o  - pop request, head-of-queue data, empty flag
// rdata_o always shows the head entry, so a pop consumes the word that is
// visible in the same cycle. Each pointer is one bit wider than the address,
// which lets the full and empty tests compare gray pointers directly.
// ASIZE must be at least 2.
module async_fifo #(
    parameter int WIDTH = 8,
    parameter int ASIZE = 3
) (
    input  logic             wclk_i,
    input  logic             wrstn_i,
    input  logic             winc_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             wfull_o,
    input  logic             rclk_i,
    input  logic             rrstn_i,
    input  logic             rinc_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             rempty_o
);

    localparam int DEPTH = 1 << ASIZE;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [ASIZE:0] wbin_q, wbin_d, wgray_q, wgray_d;
    logic [ASIZE:0] rbin_q, rbin_d, rgray_q, rgray_d;
    logic [ASIZE:0] wq1Rgray_q, wq2Rgray_q;
    logic [ASIZE:0] rq1Wgray_q, rq2Wgray_q;
    logic           wfull_q, wfull_d;
    logic           rempty_q, rempty_d;

    // Full means the next write pointer equals the read pointer with its top
    // two gray bits inverted, which is one whole lap ahead.
    assign wbin_d  = wbin_q + {{ASIZE{1'b0}}, (winc_i & ~wfull_q)};
    assign wgray_d = (wbin_d >> 1) ^ wbin_d;
    assign wfull_d = (wgray_d == {~wq2Rgray_q[ASIZE:ASIZE-1], wq2Rgray_q[ASIZE-2:0]});

    always_ff @(posedge wclk_i or negedge wrstn_i) begin
        if (!wrstn_i) begin
            wbin_q     <= '0;
            wgray_q    <= '0;
            wq1Rgray_q <= '0;
            wq2Rgray_q <= '0;
            wfull_q    <= 1'b0;
        end else begin
            wbin_q     <= wbin_d;
            wgray_q    <= wgray_d;
            wq1Rgray_q <= rgray_q;
            wq2Rgray_q <= wq1Rgray_q;
            wfull_q    <= wfull_d;
        end
    end

    always_ff @(posedge wclk_i) begin
        if (winc_i && !wfull_q) begin
            mem[wbin_q[ASIZE-1:0]] <= wdata_i;
        end
    end

    assign rbin_d   = rbin_q + {{ASIZE{1'b0}}, (rinc_i & ~rempty_q)};
    assign rgray_d  = (rbin_d >> 1) ^ rbin_d;
    assign rempty_d = (rgray_d == rq2Wgray_q);

    always_ff @(posedge rclk_i or negedge rrstn_i) begin
        if (!rrstn_i) begin
            rbin_q     <= '0;
            rgray_q    <= '0;
            rq1Wgray_q <= '0;
            rq2Wgray_q <= '0;
            rempty_q   <= 1'b1;
        end else begin
            rbin_q     <= rbin_d;
            rgray_q    <= rgray_d;
            rq1Wgray_q <= wgray_q;
            rq2Wgray_q <= rq1Wgray_q;
            rempty_q   <= rempty_d;
        end
    end

    assign rdata_o  = mem[rbin_q[ASIZE-1:0]];
    assign wfull_o  = wfull_q;
    assign rempty_o = rempty_q;

endmodule

// File: rtl/axi_to_apb_bridge.sv
// Bridge from an AXI4-Lite slave port (ACLK) to an APB3 master port (PCLK).
// Ports:
//   PCLK/PRESETN, ACLK/ARESETN     - clocks and async active-low resets per domain
//   S_AW*, S_W*, S_B*, S_AR*, S_R* - AXI4-Lite slave channels (WSTRB is ignored)
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA - APB master request outputs
//   PRDATA/PREADY/PSLVERR          - APB completion inputs
// Only one transaction is in flight at a time. Requests reach the APB side
// through the command FIFO, and the APB result returns through the response
// FIFO.
module axi_to_apb_bridge
    import axi_to_apb_bridge_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRESS    = 32,
    parameter int FIFO_ASIZE = 3
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [ADDRESS-1:0]    S_AWADDR,
    input  logic                  S_AWVALID,
    output logic                  S_AWREADY,
    input  logic [DATA_WIDTH-1:0] S_WDATA,
    input  logic [3:0]            S_WSTRB,
    input  logic                  S_WVALID,
    output logic                  S_WREADY,
    output logic [1:0]            S_BRESP,
    output logic                  S_BVALID,
    input  logic                  S_BREADY,
    input  logic [ADDRESS-1:0]    S_ARADDR,
    input  logic                  S_ARVALID,
    output logic                  S_ARREADY,
    output logic [DATA_WIDTH-1:0] S_RDATA,
    output logic [1:0]            S_RRESP,
    output logic                  S_RVALID,
    input  logic                  S_RREADY,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDRESS-1:0]    PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int CMD_W = 1 + ADDRESS + DATA_WIDTH;
    localparam int RSP_W = 1 + DATA_WIDTH + 1;

    // APB3 has no byte strobes, so the strobes are folded into an unused net.
    logic unusedStrb;
    assign unusedStrb = ^S_WSTRB;

    logic             cmdPush, cmdFull, cmdPop, cmdEmpty;
    logic [CMD_W-1:0] cmdWdata, cmdRdata;
    logic             rspPush, rspFull, rspPop, rspEmpty;
    logic [RSP_W-1:0] rspWdata, rspRdata;

    async_fifo #(.WIDTH(CMD_W), .ASIZE(FIFO_ASIZE)) u_cmdFifo (
        .wclk_i   (ACLK),
        .wrstn_i  (ARESETN),
        .winc_i   (cmdPush),
        .wdata_i  (cmdWdata),
        .wfull_o  (cmdFull),
        .rclk_i   (PCLK),
        .rrstn_i  (PRESETN),
        .rinc_i   (cmdPop),
        .rdata_o  (cmdRdata),
        .rempty_o (cmdEmpty)
    );

    async_fifo #(.WIDTH(RSP_W), .ASIZE(FIFO_ASIZE)) u_rspFifo (
        .wclk_i   (PCLK),
        .wrstn_i  (PRESETN),
        .winc_i   (rspPush),
        .wdata_i  (rspWdata),
        .wfull_o  (rspFull),
        .rclk_i   (ACLK),
        .rrstn_i  (ARESETN),
        .rinc_i   (rspPop),
        .rdata_o  (rspRdata),
        .rempty_o (rspEmpty)
    );

    // ---------------- AXI domain ----------------
    logic                  busy_q, busy_d;
    logic                  awready_q, awready_d;
    logic                  arready_q, arready_d;
    logic                  bvalid_q, bvalid_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  writeReq, canAccept;

    assign writeReq  = S_AWVALID & S_WVALID;
    // A ready pulse that is already out also blocks a new pulse, because
    // busy is only set when that handshake completes.
    assign canAccept = ~busy_q & ~awready_q & ~arready_q & ~cmdFull;

    always_comb begin
        busy_d    = busy_q;
        awready_d = 1'b0;
        arready_d = 1'b0;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        cmdPush   = 1'b0;
        cmdWdata  = {1'b0, S_ARADDR, {DATA_WIDTH{1'b0}}};
        rspPop    = 1'b0;

        // Writes take priority over reads when both are presented.
        if (canAccept && writeReq) begin
            awready_d = 1'b1;
        end else if (canAccept && S_ARVALID) begin
            arready_d = 1'b1;
        end

        if (awready_q && writeReq) begin
            cmdPush  = 1'b1;
            cmdWdata = {1'b1, S_AWADDR, S_WDATA};
            busy_d   = 1'b1;
        end else if (arready_q && S_ARVALID) begin
            cmdPush = 1'b1;
            busy_d  = 1'b1;
        end

        if (!rspEmpty && !bvalid_q && !rvalid_q) begin
            rspPop = 1'b1;
            if (rspRdata[RSP_W-1]) begin
                bvalid_d = 1'b1;
                bresp_d  = slverrToResp(rspRdata[0]);
            end else begin
                rvalid_d = 1'b1;
                rresp_d  = slverrToResp(rspRdata[0]);
                rdata_d  = rspRdata[DATA_WIDTH:1];
            end
        end

        if (bvalid_q && S_BREADY) begin
            bvalid_d = 1'b0;
            busy_d   = 1'b0;
        end
        if (rvalid_q && S_RREADY) begin
            rvalid_d = 1'b0;
            busy_d   = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            busy_q    <= 1'b0;
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            busy_q    <= busy_d;
            awready_q <= awready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign S_AWREADY = awready_q;
    assign S_WREADY  = awready_q;
    assign S_ARREADY = arready_q;
    assign S_BVALID  = bvalid_q;
    assign S_BRESP   = bresp_q;
    assign S_RVALID  = rvalid_q;
    assign S_RRESP   = rresp_q;
    assign S_RDATA   = rdata_q;

    // ---------------- APB domain ----------------
    apb_state_e            state_q, state_d;
    logic [ADDRESS-1:0]    paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  accessDone;

    // Completion also waits for space in the response FIFO. With a single
    // outstanding transaction that space is always there.
    assign accessDone = (state_q == APB_ACCESS) & PREADY & ~rspFull;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q  <= APB_IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        unique case (state_q)
            APB_IDLE: begin
                if (!cmdEmpty) begin
                    state_d  = APB_SETUP;
                    pwrite_d = cmdRdata[CMD_W-1];
                    paddr_d  = cmdRdata[ADDRESS+DATA_WIDTH-1:DATA_WIDTH];
                    pwdata_d = cmdRdata[DATA_WIDTH-1:0];
                end
            end
            APB_SETUP:  state_d = APB_ACCESS;
            APB_ACCESS: if (accessDone) state_d = APB_IDLE;
            default:    state_d = APB_IDLE;
        endcase
    end

    // PWRITE is forced low in IDLE so that every APB control is quiet between
    // transfers. The response side uses the registered copy.
    always_comb begin
        PSEL     = (state_q != APB_IDLE);
        PENABLE  = (state_q == APB_ACCESS);
        PWRITE   = (state_q != APB_IDLE) & pwrite_q;
        cmdPop   = (state_q == APB_IDLE) & ~cmdEmpty;
        rspPush  = accessDone;
        rspWdata = {pwrite_q, (pwrite_q ? {DATA_WIDTH{1'b0}} : PRDATA), PSLVERR};
    end

    assign PADDR  = paddr_q;
    assign PWDATA = pwdata_q;

endmodule

// File: tb/tb_axi_to_apb_bridge.sv
// Directed testbench for axi_to_apb_bridge. Each transaction pushes its
// expected APB request onto apbQ and its expected AXI response onto rspQ.
// An APB slave model pops apbQ at every SETUP phase. The AXI driver pops
// rspQ when BVALID or RVALID appears. The slave signals an error for any
// address above 25 and can add one wait state followed by a stale PREADY.
module tb_axi_to_apb_bridge;
    import axi_to_apb_bridge_pkg::*;

    logic        PCLK = 1'b0, ACLK = 1'b0;
    logic        PRESETN = 1'b0, ARESETN = 1'b0;
    logic [31:0] S_AWADDR = '0, S_WDATA = '0, S_ARADDR = '0;
    logic        S_AWVALID = 1'b0, S_WVALID = 1'b0, S_ARVALID = 1'b0;
    logic        S_BREADY = 1'b0, S_RREADY = 1'b0;
    logic [3:0]  S_WSTRB = 4'hF;
    logic        S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID;
    logic [1:0]  S_BRESP, S_RRESP;
    logic [31:0] S_RDATA;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0, PSLVERR = 1'b0;

    axi_to_apb_bridge #(.DATA_WIDTH(32), .ADDRESS(32), .FIFO_ASIZE(3)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
        .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #7 PCLK = ~PCLK;
    always #5 ACLK = ~ACLK;

    int   total = 0;
    int   bad = 0;
    int   nXfers = 0;
    int   apbDone = 0;
    bit   waitMode = 1'b0;
    cmd_t apbQ[$];
    rsp_t rspQ[$];
    logic [31:0] slaveMem [64];
    logic [31:0] refMem [64];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The APB slave model and monitor. It samples on the falling edge and
    // drives PREADY, PRDATA and PSLVERR for the next rising edge.
    int          accessCnt = 0;
    bit          stale = 1'b0;
    logic [31:0] curAddr = '0;
    always @(negedge PCLK) begin : apbSlave
        cmd_t c;
        if (PSEL && !PENABLE) begin
            if (apbQ.size() > 0) begin
                c = apbQ.pop_front();
                checkOutput("apb_paddr", PADDR, c.addr);
                checkOutput("apb_pwrite", PWRITE, c.write);
                checkOutput("apb_pwdata", PWDATA, c.data);
            end else begin
                checkOutput("apb_unexpected_setup", apbQ.size(), 1);
            end
            curAddr   = PADDR;
            accessCnt = 0;
            PREADY    = stale;
            stale     = 1'b0;
        end else if (PSEL && PENABLE) begin
            accessCnt++;
            checkOutput("apb_addr_stable", PADDR, curAddr);
            if (waitMode && accessCnt == 1) begin
                PREADY = 1'b0;
            end else begin
                PREADY  = 1'b1;
                PSLVERR = (PADDR > 32'd25);
                if (PWRITE) begin
                    if (!PSLVERR) slaveMem[PADDR[5:0]] = PWDATA;
                    PRDATA = 32'h0;
                end else begin
                    PRDATA = PSLVERR ? 32'h0 : slaveMem[PADDR[5:0]];
                end
                checkOutput("apb_access_len", accessCnt, waitMode ? 2 : 1);
                stale = waitMode;
                apbDone++;
            end
        end else begin
            PREADY = stale;
            stale  = 1'b0;
        end
    end

    task automatic pushExpect(input bit isWrite, input logic [31:0] addr, input logic [31:0] data);
        cmd_t c;
        rsp_t r;
        bit   err;
        err     = (addr > 32'd25);
        c.write = isWrite;
        c.addr  = addr;
        c.data  = isWrite ? data : 32'h0;
        apbQ.push_back(c);
        if (isWrite && !err) refMem[addr[5:0]] = data;
        r.write  = isWrite;
        r.rdata  = (isWrite || err) ? 32'h0 : refMem[addr[5:0]];
        r.slverr = err;
        rspQ.push_back(r);
        nXfers++;
    endtask

    task automatic waitResponse(input int holdCycles);
        rsp_t e;
        bit   got;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge ACLK);
            if (S_BVALID || S_RVALID) got = 1'b1;
        end
        checkOutput("resp_timeout", got, 1);
        if (got) begin
            if (rspQ.size() > 0) begin
                e = rspQ.pop_front();
                checkOutput("resp_kind_b", S_BVALID, e.write);
                checkOutput("resp_kind_r", S_RVALID, !e.write);
                if (e.write) begin
                    checkOutput("bresp", S_BRESP, slverrToResp(e.slverr));
                end else begin
                    checkOutput("rdata", S_RDATA, e.rdata);
                    checkOutput("rresp", S_RRESP, slverrToResp(e.slverr));
                end
                if (holdCycles > 0) begin
                    repeat (holdCycles) @(negedge ACLK);
                    checkOutput("valid_held", e.write ? S_BVALID : S_RVALID, 1);
                    if (!e.write) checkOutput("rdata_held", S_RDATA, e.rdata);
                end
            end else begin
                checkOutput("resp_unexpected", rspQ.size(), 1);
            end
            S_BREADY = 1'b1;
            S_RREADY = 1'b1;
            @(posedge ACLK);
            #1;
            S_BREADY = 1'b0;
            S_RREADY = 1'b0;
            @(negedge ACLK);
            checkOutput("valid_cleared", {S_BVALID, S_RVALID}, 2'b00);
        end
    endtask

    task automatic applyStimulus(input bit isWrite, input logic [31:0] addr,
                                 input logic [31:0] data, input int holdCycles);
        bit got;
        pushExpect(isWrite, addr, data);
        @(posedge ACLK);
        #1;
        if (isWrite) begin
            S_AWADDR = addr; S_WDATA = data; S_AWVALID = 1'b1; S_WVALID = 1'b1;
        end else begin
            S_ARADDR = addr; S_ARVALID = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge ACLK);
            got = isWrite ? (S_AWREADY && S_WREADY) : S_ARREADY;
        end
        checkOutput(isWrite ? "aw_accept_timeout" : "ar_accept_timeout", got, 1);
        @(posedge ACLK);
        #1;
        S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
        waitResponse(holdCycles);
    endtask

    initial begin : watchdog
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : mainSeq
        bit got;
        for (int i = 0; i < 64; i++) begin
            slaveMem[i] = '0;
            refMem[i]   = '0;
        end
        $display("[TB] reset phase");
        repeat (5) @(posedge PCLK);
        @(negedge ACLK);
        checkOutput("rst_ready", {S_AWREADY, S_WREADY, S_ARREADY}, 3'b000);
        checkOutput("rst_valid", {S_BVALID, S_RVALID}, 2'b00);
        checkOutput("rst_resp", {S_BRESP, S_RRESP}, 4'h0);
        checkOutput("rst_rdata", S_RDATA, 32'h0);
        checkOutput("rst_apb_ctl", {PSEL, PENABLE, PWRITE}, 3'b000);
        checkOutput("rst_apb_bus", {PADDR, PWDATA}, 64'h0);
        PRESETN = 1'b1;
        ARESETN = 1'b1;
        repeat (3) @(posedge ACLK);

        $display("[TB] basic writes");
        applyStimulus(1'b1, 32'h5, 32'hFACECAFE, 0);
        applyStimulus(1'b1, 32'h1, 32'hABCDEF12, 0);
        applyStimulus(1'b1, 32'h2, 32'hABCDEF13, 0);
        applyStimulus(1'b1, 32'h3, 32'hFACECA14, 0);
        applyStimulus(1'b1, 32'h4, 32'hABCDEF15, 0);

        $display("[TB] reads with RREADY delayed");
        applyStimulus(1'b0, 32'h3, 32'h0, 12);
        applyStimulus(1'b0, 32'h1, 32'h0, 12);
        applyStimulus(1'b0, 32'h2, 32'h0, 12);

        $display("[TB] back-to-back");
        applyStimulus(1'b1, 32'h5, 32'hDEADBEEF, 0);
        applyStimulus(1'b0, 32'h5, 32'h0, 0);

        // The write and the read are presented together, so the write must go first.
        pushExpect(1'b1, 32'h6, 32'hCAFEBABE);
        pushExpect(1'b0, 32'h6, 32'h0);
        @(posedge ACLK);
        #1;
        S_AWADDR = 32'h6; S_WDATA = 32'hCAFEBABE; S_AWVALID = 1'b1; S_WVALID = 1'b1;
        S_ARADDR = 32'h6; S_ARVALID = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge ACLK);
            got = S_AWREADY;
            if (!got) checkOutput("arb_no_early_ar", S_ARREADY, 0);
        end
        checkOutput("arb_aw_timeout", got, 1);
        checkOutput("arb_ar_blocked", S_ARREADY, 0);
        @(posedge ACLK);
        #1;
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
        waitResponse(0);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge ACLK);
            got = S_ARREADY;
        end
        checkOutput("arb_ar_timeout", got, 1);
        @(posedge ACLK);
        #1;
        S_ARVALID = 1'b0;
        waitResponse(0);

        $display("[TB] slave error");
        applyStimulus(1'b1, 32'h26, 32'h11112222, 0);
        applyStimulus(1'b0, 32'h26, 32'h0, 0);

        $display("[TB] wait state and stale PREADY");
        waitMode = 1'b1;
        applyStimulus(1'b1, 32'h7, 32'h12345678, 0);
        applyStimulus(1'b0, 32'h7, 32'h0, 0);
        applyStimulus(1'b0, 32'h5, 32'h0, 0);
        waitMode = 1'b0;

        repeat (10) @(posedge PCLK);
        checkOutput("apb_queue_drained", apbQ.size(), 0);
        checkOutput("rsp_queue_drained", rspQ.size(), 0);
        checkOutput("apb_transfer_count", apbDone, nXfers);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
